// File: rtl/rv32i_run_ctrl.sv
// rv32i_run_ctrl
//
// Run controller placed directly upstream of the multi-cycle RV32I core.
// It accepts a run request (instruction count) over a valid/ready handshake,
// holds the core in reset for RST_CYCLES cycles, releases it, and counts
// RUN cycles until the core raises eof or TIMEOUT cycles have elapsed. The
// cycle count and a timeout flag are returned over a second valid/ready
// handshake.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   start_valid   run request valid
//   start_ready   controller can accept a request (IDLE)
//   start_count   instructions to execute, sampled on accept
//   core_rst      active-low core reset, high only while running
//   no_instruct   instruction count driven to the core
//   eof           core end-of-program flag
//   done_valid    result valid
//   done_ready    result consumed
//   done_cycles   RUN cycles consumed
//   done_timeout  run ended by timeout rather than eof
module rv32i_run_ctrl #(
  parameter int NI_W       = 6,
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [NI_W-1:0]   start_count,
  output logic              core_rst,
  output logic [NI_W-1:0]   no_instruct,
  input  logic              eof,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [CYC_W-1:0]  done_cycles,
  output logic              done_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  // The reset counter only has to reach RST_CYCLES-1.
  localparam int              RST_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               start_ready_d;
  logic               core_rst_d;
  logic [NI_W-1:0]    no_instruct_d;
  logic               done_valid_d;
  logic [CYC_W-1:0]   done_cycles_d;
  logic               done_timeout_d;

  // Count including the current RUN cycle; the first RUN cycle counts as 1.
  logic [CYC_W-1:0]   cyc_inc;
  assign cyc_inc = cyc_cnt_q + CYC_W'(1);

  // Next-state and next-output logic. Every output is produced here as a
  // _d value and registered below, so all outputs are glitch-free flops.
  always_comb begin
    // NOTE: every variable gets a default before the case statement; a path
    // that leaves one unassigned would otherwise infer a latch.
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    cyc_cnt_d      = cyc_cnt_q;
    start_ready_d  = start_ready;
    core_rst_d     = core_rst;
    no_instruct_d  = no_instruct;
    done_valid_d   = done_valid;
    done_cycles_d  = done_cycles;
    done_timeout_d = done_timeout;

    case (state_q)
      S_IDLE: begin
        // Ready rises on the first edge after reset release and stays high
        // for as long as we wait in IDLE.
        start_ready_d = 1'b1;
        core_rst_d    = 1'b0;
        if (start_valid && start_ready) begin
          start_ready_d = 1'b0;
          no_instruct_d = start_count;
          cyc_cnt_d     = '0;
          rst_cnt_d     = '0;
          if (start_count == '0) begin
            // Nothing to execute: report an empty run immediately.
            state_d        = S_DONE;
            done_valid_d   = 1'b1;
            done_cycles_d  = '0;
            done_timeout_d = 1'b0;
          end else begin
            state_d = S_RESET;
          end
        end
      end

      S_RESET: begin
        // eof is deliberately not looked at while the core is held in reset.
        if (rst_cnt_q == RST_LAST) begin
          state_d    = S_RUN;
          core_rst_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      S_RUN: begin
        cyc_cnt_d = cyc_inc;
        // eof is tested first so it wins over a coincident timeout.
        if (eof) begin
          state_d        = S_DONE;
          core_rst_d     = 1'b0;
          done_valid_d   = 1'b1;
          done_cycles_d  = cyc_inc;
          done_timeout_d = 1'b0;
        end else if (cyc_inc == TIMEOUT_C) begin
          state_d        = S_DONE;
          core_rst_d     = 1'b0;
          done_valid_d   = 1'b1;
          done_cycles_d  = TIMEOUT_C;
          done_timeout_d = 1'b1;
        end
      end

      S_DONE: begin
        // Result fields are simply not touched here, so they stay stable
        // until the consumer takes them.
        core_rst_d = 1'b0;
        if (done_ready) begin
          state_d       = S_IDLE;
          done_valid_d  = 1'b0;
          start_ready_d = 1'b1;
        end
      end

      default: begin
        state_d       = S_IDLE;
        start_ready_d = 1'b0;
        core_rst_d    = 1'b0;
        done_valid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. Asserting rst drops core_rst and discards
  // any in-flight result without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      start_ready  <= 1'b0;
      core_rst     <= 1'b0;
      no_instruct  <= '0;
      done_valid   <= 1'b0;
      done_cycles  <= '0;
      done_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      start_ready  <= start_ready_d;
      core_rst     <= core_rst_d;
      no_instruct  <= no_instruct_d;
      done_valid   <= done_valid_d;
      done_cycles  <= done_cycles_d;
      done_timeout <= done_timeout_d;
    end
  end

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Self-checking bench for rv32i_run_ctrl: directed scenarios followed by
// randomized runs, with expected results computed from a simple model of
// what a run should return (count, eof cycle, timeout).
module tb_rv32i_run_ctrl;

  localparam int NI_W       = 6;
  localparam int CYC_W      = 32;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 16;

  logic              clk;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic [NI_W-1:0]   start_count;
  logic              core_rst;
  logic [NI_W-1:0]   no_instruct;
  logic              eof;
  logic              done_valid;
  logic              done_ready;
  logic [CYC_W-1:0]  done_cycles;
  logic              done_timeout;

  int checks = 0;
  int errors = 0;

  rv32i_run_ctrl #(
    .NI_W       (NI_W),
    .CYC_W      (CYC_W),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_count  (start_count),
    .core_rst     (core_rst),
    .no_instruct  (no_instruct),
    .eof          (eof),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_cycles  (done_cycles),
    .done_timeout (done_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what a run must report.
  function automatic int model_cycles(input int count, input int eof_at);
    if (count == 0) return 0;
    if (eof_at > 0 && eof_at <= TIMEOUT) return eof_at;
    return TIMEOUT;
  endfunction

  function automatic int model_timeout(input int count, input int eof_at);
    if (count == 0) return 0;
    return (eof_at > 0 && eof_at <= TIMEOUT) ? 0 : 1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"},  32'(start_ready), 0);
    check({tag, "_core_rst"},     32'(core_rst), 0);
    check({tag, "_no_instruct"},  32'(no_instruct), 0);
    check({tag, "_done_valid"},   32'(done_valid), 0);
    check({tag, "_done_cycles"},  32'(done_cycles), 0);
    check({tag, "_done_timeout"}, 32'(done_timeout), 0);
  endtask

  // Wait (bounded) for the controller to be ready, then accept a request.
  task automatic accept(input int count);
    int w = 0;
    while (!start_ready && w < 10) begin
      step();
      w++;
    end
    check("ready_before_accept", 32'(start_ready), 1);
    start_valid = 1'b1;
    start_count = NI_W'(count);
    step();
    start_valid = 1'b0;
    check("ready_drop_on_accept", 32'(start_ready), 0);
    check("no_instruct_latched", 32'(no_instruct), 32'(count));
  endtask

  // One complete transaction. eof_at = RUN cycle on which eof is raised
  // (0 = never). delay = cycles done_ready is held low; during that wait a
  // competing start_valid is driven and must be ignored.
  task automatic run_txn(input int count, input int eof_at, input int delay);
    int exp_cyc;
    int exp_to;
    int low_cnt;
    int run_n;
    bit fin;
    bit run_drop;
    bit unstable;
    logic [CYC_W-1:0] held_cycles;
    logic held_to;

    exp_cyc = model_cycles(count, eof_at);
    exp_to  = model_timeout(count, eof_at);
    eof = 1'b0;
    done_ready = 1'b0;
    accept(count);

    if (count != 0) begin
      // eof is driven high during the core-reset window; it must be ignored.
      low_cnt = 1;
      eof = 1'b1;
      while (!core_rst && low_cnt < 20) begin
        step();
        if (!core_rst) low_cnt++;
      end
      check("core_rst_low_cycles", 32'(low_cnt), RST_CYCLES);
      check("no_done_in_reset", 32'(done_valid), 0);

      run_n = 1;
      fin = 1'b0;
      run_drop = 1'b0;
      while (!fin && run_n <= 40) begin
        eof = (run_n == eof_at);
        step();
        if (done_valid) fin = 1'b1;
        else begin
          if (!core_rst) run_drop = 1'b1;
          run_n++;
        end
      end
      eof = 1'b0;
      check("run_length", 32'(run_n), 32'(exp_cyc));
      check("core_rst_high_in_run", 32'(run_drop), 0);
    end

    check("done_valid", 32'(done_valid), 1);
    check("done_cycles", done_cycles, 32'(exp_cyc));
    check("done_timeout", 32'(done_timeout), 32'(exp_to));
    check("core_rst_low_in_done", 32'(core_rst), 0);
    check("ready_low_in_done", 32'(start_ready), 0);

    held_cycles = done_cycles;
    held_to = done_timeout;
    unstable = 1'b0;
    for (int i = 0; i < delay; i++) begin
      start_valid = 1'b1;
      start_count = NI_W'(count + 1);
      step();
      if (!done_valid || start_ready || done_cycles !== held_cycles ||
          done_timeout !== held_to || core_rst) unstable = 1'b1;
    end
    if (delay > 0) check("done_held_stable", 32'(unstable), 0);
    start_valid = 1'b0;
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    check("done_valid_drop", 32'(done_valid), 0);
    check("ready_back_in_idle", 32'(start_ready), 1);
    check("no_instruct_held", 32'(no_instruct), 32'(count));
  endtask

  initial begin
    rst = 1'b0;
    start_valid = 1'b0;
    start_count = '0;
    eof = 1'b0;
    done_ready = 1'b0;

    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(start_ready), 0);
    step();
    check("ready_after_release", 32'(start_ready), 1);

    // Directed scenarios.
    run_txn(5, 7, 0);     // basic run
    run_txn(0, 3, 0);     // zero count goes straight to DONE
    run_txn(9, 0, 1);     // no eof -> timeout at TIMEOUT
    run_txn(4, 16, 0);    // eof coincides with timeout, eof wins
    run_txn(6, 2, 10);    // consumer stalls for 10 cycles
    run_txn(3, 1, 0);     // follow-up request of 3, eof on first RUN cycle

    // Asynchronous reset in the middle of a run.
    accept(9);
    while (!core_rst && checks < 100000) step();
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrun");
    step();
    step();
    check("midrun_no_done", 32'(done_valid), 0);
    rst = 1'b1;
    step();
    check("midrun_ready_after_release", 32'(start_ready), 1);
    check("midrun_still_no_done", 32'(done_valid), 0);
    run_txn(5, 7, 0);

    // Randomized runs.
    for (int t = 0; t < 40; t++) begin
      run_txn(int'($urandom_range(0, 63)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
